serial_word_driver: RTL and testbench

Parallel-side driver for the serial two's-complement FSM. It accepts a WIDTH-bit word over a valid/ready handshake, clears the FSM, and shifts the word out LSB-first on a serial bit line. It then collects the FSM's registered serial output back into a parallel result word and flags any mismatch against the arithmetic two's complement. It sits between the parallel test/host logic and the serial complementer, acting as both transmitter and collector for that bit-stream interface.

---
 rtl/serial_pkg.sv | 19 +
 rtl/shift_reg_lsb.sv | 25 ++
 rtl/serial_word_driver.sv | 108 ++++++++++
 tb/tb_serial_word_driver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and sizing for the serial complementer driver.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Bit-counter width for a given word length (word length is at least 2).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_reg_lsb.sv
// Parallel-load shift register: shifts right, serial in at MSB, serial out is q[0].
module shift_reg_lsb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // Load has priority over shift; reset clears the contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_word_driver.sv
// Drives a word LSB-first into the serial complementer and collects its
// registered serial output back into a parallel result with an error flag.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// CLEAR | one-cycle clear pulse to the complementer
// SHIFT | WIDTH cycles driving TX bits; captures start one cycle late
// DRAIN | captures the last returned bit
// DONE  | result held until res_ready
module serial_word_driver
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_clr,
  input  logic             ser_in,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  input  logic             res_ready
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] neg_word;
  logic             tx_load;
  logic             tx_shift;
  logic             rx_shift;

  assign tx_load  = (state == IDLE) && in_valid;
  assign tx_shift = (state == SHIFT);
  // The complementer output is registered, so the first returned bit
  // only appears in SHIFT cycle 1 and the last one in DRAIN.
  assign rx_shift = ((state == SHIFT) && (cnt != '0)) || (state == DRAIN);

  shift_reg_lsb #(.WIDTH(WIDTH)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (tx_load),
    .load_data (in_data),
    .shift     (tx_shift),
    .sin       (1'b0),
    .q         (tx_q)
  );

  shift_reg_lsb #(.WIDTH(WIDTH)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ('0),
    .shift     (rx_shift),
    .sin       (ser_in),
    .q         (rx_q)
  );

  // Sequencer: state, bit counter and the reference copy of the word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      word  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word  <= in_data;
            cnt   <= '0;
            state <= CLEAR;
          end
        end
        CLEAR: state <= SHIFT;
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DRAIN;
        end
        DRAIN: state <= DONE;
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reference two's complement; carry out is dropped by the width.
  assign neg_word = ~word + WIDTH'(1);

  assign in_ready  = (state == IDLE);
  assign ser_out   = (state == SHIFT) ? tx_q[0] : 1'b0;
  // Held high during reset so the complementer is cleared alongside us.
  assign ser_clr   = (state == CLEAR) || !reset;
  assign res_valid = (state == DONE);
  assign res_data  = rx_q;
  assign res_err   = (state == DONE) && (rx_q != neg_word);

endmodule

// File: tb/tb_serial_word_driver.sv
module tb_serial_word_driver;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         ser_out;
  logic         ser_clr;
  logic         ser_in;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_err;
  logic         res_ready = 1'b1;

  always #5 clk = ~clk;

  serial_word_driver #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_clr   (ser_clr),
    .ser_in    (ser_in),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_err   (res_err),
    .res_ready (res_ready)
  );

  // Serial complementer: copy bits up to and including the first 1, invert after.
  logic fsm_out = 1'b0;
  logic fsm_seen = 1'b0;
  logic lb_q = 1'b0;
  logic loopback = 1'b0;

  always @(posedge clk) begin
    if (ser_clr) begin
      fsm_out  <= 1'b0;
      fsm_seen <= 1'b0;
    end else begin
      fsm_out  <= fsm_seen ? ~ser_out : ser_out;
      fsm_seen <= fsm_seen | ser_out;
    end
    lb_q <= ser_out;
  end

  assign ser_in = loopback ? lb_q : fsm_out;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  function automatic exp_t model(input logic [W-1:0] w, input logic lb);
    exp_t r;
    logic [W-1:0] neg;
    neg = ~w + 8'd1;
    if (lb) begin
      r.data = w;
      r.err  = (w != neg);
    end else begin
      r.data = neg;
      r.err  = 1'b0;
    end
    return r;
  endfunction

  int   clr_pulses = 0;
  logic clr_prev = 1'b0;

  // Push on accept, pop and compare on result handshake, count clear pulses.
  always @(negedge clk) begin
    if (reset && in_valid && in_ready) sb.push_back(model(in_data, loopback));
    if (reset && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("res_data", {24'd0, res_data}, {24'd0, e.data});
        check("res_err", {31'd0, res_err}, {31'd0, e.err});
      end
    end
    if (reset && ser_clr && !clr_prev) clr_pulses++;
    clr_prev = ser_clr && reset;
  end

  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    check("accept_timeout", {31'd0, n < 200}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sb.size() == 0 && in_ready) && n < 300);
    check("idle_timeout", {31'd0, n < 300}, 32'd1);
  endtask

  logic [W-1:0] bits;
  logic [W-1:0] bvec [4] = '{8'h00, 8'h01, 8'h80, 8'hFF};

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_err", {31'd0, res_err}, 32'd0);
    check("rst_res_data", {24'd0, res_data}, 32'd0);
    check("rst_ser_out", {31'd0, ser_out}, 32'd0);
    check("rst_ser_clr", {31'd0, ser_clr}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("idle_ser_clr", {31'd0, ser_clr}, 32'd0);

    // 0x6C: serial sequence, clear pulse and latency (valid in cycle t+11)
    send(8'h6C);
    @(negedge clk);
    check("clear_cycle", {31'd0, ser_clr}, 32'd1);
    check("clear_no_valid", {31'd0, res_valid}, 32'd0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      bits[i] = ser_out;
    end
    check("ser_out_seq", {24'd0, bits}, 32'h6C);
    @(negedge clk);
    check("drain_ser_out", {31'd0, ser_out}, 32'd0);
    check("drain_no_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    check("latency_valid", {31'd0, res_valid}, 32'd1);
    wait_idle();

    // Boundary words
    for (int i = 0; i < 4; i++) send(bvec[i]);
    wait_idle();

    // Backpressure: hold result, second word must wait
    @(posedge clk); #1;
    res_ready = 1'b0;
    send(8'h55);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_timeout", {31'd0, n < 50}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", {31'd0, res_valid}, 32'd1);
      check("hold_data", {24'd0, res_data}, 32'hAB);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    check("done_blocks_input", {31'd0, in_ready}, 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    check("bp_accept_timeout", {31'd0, n < 20}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();

    // Faulty loopback: returned word equals input
    loopback = 1'b1;
    send(8'h6C);
    send(8'h00);
    wait_idle();
    loopback = 1'b0;

    // Reset in SHIFT at counter 3
    send(8'h77);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_ser_clr", {31'd0, ser_clr}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_ser_clr_off", {31'd0, ser_clr}, 32'd0);
    send(8'h01);
    wait_idle();

    // Back-to-back, one clear pulse per word
    clr_pulses = 0;
    send(8'h03);
    send(8'h10);
    wait_idle();
    check("clr_pulses", clr_pulses, 32'd2);

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
